// File: rtl/conv_8b_32b.sv
// Receive-side byte packer: gathers four contiguous valid bytes from the
// deserializer lane and presents them as one 32-bit word with a valid pulse.
module conv_8b_32b #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_8_in,
  input  logic        valid_8_in,
  output logic [31:0] data_32_out,
  output logic        valid_32_out,
  output logic        err_partial
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned SHIFT_W = 3 * BYTE_W;
  localparam int unsigned WORD_W  = 4 * BYTE_W;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(3);

  logic [CNT_W-1:0]   byte_cnt;
  logic [SHIFT_W-1:0] shift;
  logic [WORD_W-1:0]  word_c;

  // Slot 0 of shift holds the first byte of the word, slot 2 the third.
  always_comb begin
    word_c = '0;
    if (MSB_FIRST != 0) begin
      word_c = {shift[7:0], shift[15:8], shift[23:16], data_8_in};
    end else begin
      word_c = {data_8_in, shift[23:16], shift[15:8], shift[7:0]};
    end
  end

  // Capture, word completion and partial-word discard.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      byte_cnt     <= '0;
      shift        <= '0;
      data_32_out  <= '0;
      valid_32_out <= 1'b0;
      err_partial  <= 1'b0;
    end else begin
      valid_32_out <= 1'b0;
      err_partial  <= 1'b0;
      if (valid_8_in) begin
        if (byte_cnt == LAST_SLOT) begin
          data_32_out  <= word_c;
          valid_32_out <= 1'b1;
          byte_cnt     <= '0;
        end else begin
          case (byte_cnt)
            CNT_W'(0): shift[7:0]   <= data_8_in;
            CNT_W'(1): shift[15:8]  <= data_8_in;
            default:   shift[23:16] <= data_8_in;
          endcase
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end else if (byte_cnt != '0) begin
        // A gap inside a word drops it; shift is simply overwritten later.
        byte_cnt    <= '0;
        err_partial <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_8b_32b.sv
// Self-checking bench for conv_8b_32b: both byte orders run side by side
// against a queue of expected words built as bytes are driven.
module tb_conv_8b_32b;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  data_8_in;
  logic        valid_8_in;
  logic [31:0] data_msb, data_lsb;
  logic        valid_msb, valid_lsb, err_msb, err_lsb;

  conv_8b_32b #(.MSB_FIRST(1)) dut_msb (
    .clk_4f(clk_4f), .reset(reset), .data_8_in(data_8_in), .valid_8_in(valid_8_in),
    .data_32_out(data_msb), .valid_32_out(valid_msb), .err_partial(err_msb)
  );

  conv_8b_32b #(.MSB_FIRST(0)) dut_lsb (
    .clk_4f(clk_4f), .reset(reset), .data_8_in(data_8_in), .valid_8_in(valid_8_in),
    .data_32_out(data_lsb), .valid_32_out(valid_lsb), .err_partial(err_lsb)
  );

  always #5 clk_4f = ~clk_4f;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] q_msb[$];
  logic [31:0] q_lsb[$];
  logic [7:0]  mbytes[4];
  int          mcnt = 0;
  logic        exp_valid = 1'b0;
  logic        exp_err   = 1'b0;
  logic [31:0] hold_msb  = 32'h0;
  logic [31:0] hold_lsb  = 32'h0;

  // Drive one cycle of input, update the reference model, step past the edge.
  task automatic drive(input logic v, input logic [7:0] d);
    valid_8_in = v;
    data_8_in  = d;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
    if (v) begin
      mbytes[mcnt] = d;
      if (mcnt == 3) begin
        q_msb.push_back({mbytes[0], mbytes[1], mbytes[2], mbytes[3]});
        q_lsb.push_back({mbytes[3], mbytes[2], mbytes[1], mbytes[0]});
        exp_valid = 1'b1;
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end else begin
      exp_err = (mcnt != 0);
      mcnt = 0;
    end
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_8_in = 1'b0; data_8_in = 8'h00;
    repeat (3) @(posedge clk_4f);
    #1;
    n_checks++; if ({valid_msb, err_msb, valid_lsb, err_lsb} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {valid_msb, err_msb, valid_lsb, err_lsb}); else n_pass++;
    n_checks++; if (data_msb !== 32'h0) $display("FAIL reset_data_msb: got %h want 00000000", data_msb); else n_pass++;
    n_checks++; if (data_lsb !== 32'h0) $display("FAIL reset_data_lsb: got %h want 00000000", data_lsb); else n_pass++;
    #3 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'h00);
      n_checks++; if ({valid_msb, err_msb, valid_lsb, err_lsb} !== 4'b0) $display("FAIL idle_flags[%0d]: got %b want 0000", i, {valid_msb, err_msb, valid_lsb, err_lsb}); else n_pass++;
      n_checks++; if ({data_msb, data_lsb} !== 64'h0) $display("FAIL idle_data[%0d]: got %h want 0", i, {data_msb, data_lsb}); else n_pass++;
    end
  endtask

  task automatic test_single_word();
    logic [7:0] b[8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, b[i]);
      if (valid_msb && q_msb.size() != 0) hold_msb = q_msb.pop_front();
      if (valid_lsb && q_lsb.size() != 0) hold_lsb = q_lsb.pop_front();
      n_checks++; if ({valid_msb, valid_lsb} !== {2{exp_valid}}) $display("FAIL single_valid[%0d]: got %b want %b", i, {valid_msb, valid_lsb}, {2{exp_valid}}); else n_pass++;
      n_checks++; if ({err_msb, err_lsb} !== {2{exp_err}}) $display("FAIL single_err[%0d]: got %b want %b", i, {err_msb, err_lsb}, {2{exp_err}}); else n_pass++;
      n_checks++; if (data_msb !== hold_msb) $display("FAIL single_data_msb[%0d]: got %h want %h", i, data_msb, hold_msb); else n_pass++;
      n_checks++; if (data_lsb !== hold_lsb) $display("FAIL single_data_lsb[%0d]: got %h want %h", i, data_lsb, hold_lsb); else n_pass++;
      if (i >= 3) begin
        n_checks++; if (data_msb !== 32'hDEADBEEF) $display("FAIL single_const[%0d]: got %h want deadbeef", i, data_msb); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    int last_pulse = -1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, b[i]);
      if (valid_msb && q_msb.size() != 0) hold_msb = q_msb.pop_front();
      if (valid_lsb && q_lsb.size() != 0) hold_lsb = q_lsb.pop_front();
      n_checks++; if ({valid_msb, valid_lsb} !== {2{exp_valid}}) $display("FAIL stream_valid[%0d]: got %b want %b", i, {valid_msb, valid_lsb}, {2{exp_valid}}); else n_pass++;
      n_checks++; if ({err_msb, err_lsb} !== 2'b00) $display("FAIL stream_err[%0d]: got %b want 00", i, {err_msb, err_lsb}); else n_pass++;
      n_checks++; if (data_msb !== hold_msb) $display("FAIL stream_data_msb[%0d]: got %h want %h", i, data_msb, hold_msb); else n_pass++;
      n_checks++; if (data_lsb !== hold_lsb) $display("FAIL stream_data_lsb[%0d]: got %h want %h", i, data_lsb, hold_lsb); else n_pass++;
      if (valid_msb) begin
        if (last_pulse >= 0) begin
          n_checks++; if (i - last_pulse !== 4) $display("FAIL stream_spacing: got %0d want 4", i - last_pulse); else n_pass++;
        end
        last_pulse = i;
      end
    end
    n_checks++; if (data_msb !== 32'h55667788) $display("FAIL stream_last: got %h want 55667788", data_msb); else n_pass++;
  endtask

  task automatic test_gap_discard();
    logic [7:0] b[8] = '{8'hA1, 8'hA2, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    logic       v[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int err_seen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(v[i], b[i]);
      if (valid_msb && q_msb.size() != 0) hold_msb = q_msb.pop_front();
      if (valid_lsb && q_lsb.size() != 0) hold_lsb = q_lsb.pop_front();
      if (err_msb) err_seen++;
      n_checks++; if ({valid_msb, valid_lsb} !== {2{exp_valid}}) $display("FAIL gap_valid[%0d]: got %b want %b", i, {valid_msb, valid_lsb}, {2{exp_valid}}); else n_pass++;
      n_checks++; if ({err_msb, err_lsb} !== {2{exp_err}}) $display("FAIL gap_err[%0d]: got %b want %b", i, {err_msb, err_lsb}, {2{exp_err}}); else n_pass++;
      n_checks++; if (data_msb !== hold_msb) $display("FAIL gap_data_msb[%0d]: got %h want %h", i, data_msb, hold_msb); else n_pass++;
      n_checks++; if (data_lsb !== hold_lsb) $display("FAIL gap_data_lsb[%0d]: got %h want %h", i, data_lsb, hold_lsb); else n_pass++;
      if (i == 2) begin
        n_checks++; if (data_msb !== 32'h55667788) $display("FAIL gap_hold: got %h want 55667788", data_msb); else n_pass++;
      end
    end
    n_checks++; if (err_seen !== 1) $display("FAIL gap_err_count: got %0d want 1", err_seen); else n_pass++;
    n_checks++; if (data_msb !== 32'h01020304) $display("FAIL gap_word: got %h want 01020304", data_msb); else n_pass++;
    n_checks++; if (data_lsb !== 32'h04030201) $display("FAIL lsb_order: got %h want 04030201", data_lsb); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] pre[3]  = '{8'hC1, 8'hC2, 8'hC3};
    logic [7:0] post[5] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pre[i]);
      n_checks++; if ({valid_msb, err_msb} !== 2'b00) $display("FAIL pre_reset_flags[%0d]: got %b want 00", i, {valid_msb, err_msb}); else n_pass++;
    end
    #2 reset = 1'b0; valid_8_in = 1'b0;
    #1;
    mcnt = 0; hold_msb = 32'h0; hold_lsb = 32'h0; q_msb.delete(); q_lsb.delete();
    n_checks++; if ({data_msb, data_lsb} !== 64'h0) $display("FAIL async_data: got %h want 0", {data_msb, data_lsb}); else n_pass++;
    n_checks++; if ({valid_msb, err_msb, valid_lsb, err_lsb} !== 4'b0) $display("FAIL async_flags: got %b want 0000", {valid_msb, err_msb, valid_lsb, err_lsb}); else n_pass++;
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, post[i]);
      if (valid_msb && q_msb.size() != 0) hold_msb = q_msb.pop_front();
      if (valid_lsb && q_lsb.size() != 0) hold_lsb = q_lsb.pop_front();
      n_checks++; if ({valid_msb, valid_lsb} !== {2{exp_valid}}) $display("FAIL post_valid[%0d]: got %b want %b", i, {valid_msb, valid_lsb}, {2{exp_valid}}); else n_pass++;
      n_checks++; if ({err_msb, err_lsb} !== {2{exp_err}}) $display("FAIL post_err[%0d]: got %b want %b", i, {err_msb, err_lsb}, {2{exp_err}}); else n_pass++;
      n_checks++; if (data_msb !== hold_msb) $display("FAIL post_data_msb[%0d]: got %h want %h", i, data_msb, hold_msb); else n_pass++;
      n_checks++; if (data_lsb !== hold_lsb) $display("FAIL post_data_lsb[%0d]: got %h want %h", i, data_lsb, hold_lsb); else n_pass++;
    end
    n_checks++; if (data_msb !== 32'h0A0B0C0D) $display("FAIL post_word: got %h want 0a0b0c0d", data_msb); else n_pass++;
    n_checks++; if (q_msb.size() !== 0) $display("FAIL post_queue: got %0d pending want 0", q_msb.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap_discard();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
